param_stream_loader: RTL and testbench
======================================

PARAM_STREAM_LOADER -- requirements
Module: param_stream_loader

Interface
REQ-001 Parameter DATA_W, default 32: word width (IEEE-754 single-precision filter/weight words).
REQ-002 Parameter CH, default 6: number of channels (filters) held.
REQ-003 Parameter ROWS, default 5: rows per channel.
REQ-004 Parameter COLS, default 5: columns per channel.
REQ-005 Derived, not overridable: TOTAL=CH*ROWS*COLS; CW=max(1,clog2(CH)); RW=max(1,clog2(ROWS)); LW=max(1,clog2(COLS)); NW=clog2(TOTAL+1).
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 start  input  1  one-cycle request to begin a load.
REQ-009 abort  input  1  cancel an in-progress load.
REQ-010 in_valid  input  1  in_data holds a word.
REQ-011 in_data  input  DATA_W  streamed word.
REQ-012 in_ready  output  1  block accepts a word this cycle.
REQ-013 rd_en  input  1  read request.
REQ-014 rd_ch / rd_row / rd_col  input  CW / RW / LW  read address.
REQ-015 rd_data  output  DATA_W  read result.
REQ-016 rd_valid  output  1  rd_data valid this cycle.
REQ-017 busy  output  1  load in progress.
REQ-018 done  output  1  buffer fully loaded.
REQ-019 count  output  NW  words accepted in the current/last load.
REQ-020 checksum  output  DATA_W  XOR of all words accepted in the current/last load.

Function
REQ-021 FSM states IDLE, LOAD, DONE; busy=1 only in LOAD; done=1 only in DONE; in_ready=1 only in LOAD.
REQ-022 IDLE or DONE, start=1 -> LOAD next cycle; count, checksum, write pointer cleared to 0 on that edge; done drops same edge.
REQ-023 start while in LOAD is ignored.
REQ-024 A word is accepted only when in_valid=1 and in_ready=1; in_data is ignored otherwise.
REQ-025 Accepted word k (0-based) stored at ch=k/(ROWS*COLS), row=(k/COLS)%ROWS, col=k%COLS: col fastest, then row, then channel.
REQ-026 Each accept: count+1, checksum ^= in_data, both visible the cycle after the accept.
REQ-027 Accept of word TOTAL-1 -> DONE next cycle; no further words accepted (in_ready=0 in DONE).
REQ-028 abort=1 in LOAD -> IDLE next cycle; memory words already written are kept; count/checksum hold their values; abort has priority over a same-cycle accept (word not written, not counted).
REQ-029 abort in IDLE or DONE has no effect.
REQ-030 Read port: rd_en sampled at edge; rd_data/rd_valid registered, one-cycle latency; rd_valid=0 when rd_en was 0.
REQ-031 Reads are allowed in any state; read of a location written on the same edge returns the old content.
REQ-032 Out-of-range read (rd_ch>=CH or rd_row>=ROWS or rd_col>=COLS): rd_valid=1, rd_data=0.
REQ-033 Memory contents are not reset; unwritten locations return an undefined value.

Reset
REQ-034 rst_n=0 forces immediately: state IDLE, in_ready=0, busy=0, done=0, count=0, checksum=0, rd_valid=0, rd_data=0, write pointer 0.
REQ-035 Reset asserted mid-LOAD discards the load; after release the block is in IDLE and waits for start.
REQ-036 First edge after rst_n rises: normal operation; a start on that edge is honoured.

Verification
REQ-037 Defaults, start, then 150 words 0x3F800000+k with in_valid always 1 -> in_ready high 150 cycles, done=1 cycle after the last accept, count=150, read (5,4,4) returns 0x3F800095 one cycle later.
REQ-038 in_valid toggled 1/0 each cycle during load -> only valid cycles counted; done after 150 accepts (~300 cycles); all 150 addresses read back correctly.
REQ-039 abort asserted after 37 accepts, same cycle as in_valid=1 -> IDLE, count=37, word 37 not written; new start clears count to 0.
REQ-040 rst_n pulsed low after 80 accepts -> all outputs at REQ-034 values asynchronously; done stays 0 until a fresh full load completes.
REQ-041 Read (6,0,0) and (0,5,0) -> rd_valid=1, rd_data=0; read of address being written in the same cycle returns prior content.
REQ-042 Override CH=16, ROWS=5, COLS=5 -> 400 words to done; checksum equals software XOR of the stream.

Source files
------------

// File: rtl/param_stream_loader.sv
// Loads a stream of CH*ROWS*COLS parameter words into a channel/row/column
// buffer and offers a registered random-access read port with a running XOR checksum.
module param_stream_loader #(
    parameter int DATA_W = 32,
    parameter int CH     = 6,
    parameter int ROWS   = 5,
    parameter int COLS   = 5,
    localparam int TOTAL = CH * ROWS * COLS,
    localparam int CW    = (CH   > 1) ? $clog2(CH)   : 1,
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int LW    = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int NW    = $clog2(TOTAL + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              rd_en,
    input  logic [CW-1:0]     rd_ch,
    input  logic [RW-1:0]     rd_row,
    input  logic [LW-1:0]     rd_col,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic [NW-1:0]     count,
    output logic [DATA_W-1:0] checksum
);

    // state  | meaning
    // S_IDLE | waiting for start, nothing loaded or load abandoned
    // S_LOAD | accepting stream words into the buffer
    // S_DONE | buffer holds a complete load, waiting for a new start
    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic              accept;
    logic              last_word;
    logic              rd_in_range;
    logic [CW-1:0]     wr_ch;
    logic [RW-1:0]     wr_row;
    logic [LW-1:0]     wr_col;
    logic [DATA_W-1:0] mem [CH][ROWS][COLS];

    // abort wins over a same-cycle accept: the word is neither stored nor counted
    assign accept    = (state == S_LOAD) && in_valid && !abort;
    assign last_word = (count == NW'(TOTAL - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (accept && last_word) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_nxt = S_LOAD;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Write pointer kept as separate col/row/channel counters so no divide is needed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            checksum <= '0;
            wr_ch    <= '0;
            wr_row   <= '0;
            wr_col   <= '0;
        end else if ((state != S_LOAD) && start) begin
            count    <= '0;
            checksum <= '0;
            wr_ch    <= '0;
            wr_row   <= '0;
            wr_col   <= '0;
        end else if (accept) begin
            count    <= count + 1'b1;
            checksum <= checksum ^ in_data;
            if (wr_col == LW'(COLS - 1)) begin
                wr_col <= '0;
                if (wr_row == RW'(ROWS - 1)) begin
                    wr_row <= '0;
                    wr_ch  <= wr_ch + 1'b1;
                end else begin
                    wr_row <= wr_row + 1'b1;
                end
            end else begin
                wr_col <= wr_col + 1'b1;
            end
        end
    end

    // Buffer storage is deliberately left without reset
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ch][wr_row][wr_col] <= in_data;
        end
    end

    assign rd_in_range = (int'(rd_ch) < CH) && (int'(rd_row) < ROWS) && (int'(rd_col) < COLS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_in_range ? mem[rd_ch][rd_row][rd_col] : '0;
            end
        end
    end

endmodule

// File: tb/tb_param_stream_loader.sv
// Scoreboarded bench for param_stream_loader: reads push expected words into a
// queue that a negedge monitor drains; control/status outputs are checked inline.
module tb_param_stream_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort, in_valid, rd_en;
    logic [31:0] in_data;
    logic [2:0]  rd_ch, rd_row, rd_col;
    logic        in_ready, rd_valid, busy, done;
    logic [31:0] rd_data, checksum;
    logic [7:0]  count;

    logic        start2, abort2, in_valid2, rd_en2;
    logic [31:0] in_data2;
    logic [3:0]  rd_ch2;
    logic [2:0]  rd_row2, rd_col2;
    logic        in_ready2, rd_valid2, busy2, done2;
    logic [31:0] rd_data2, checksum2;
    logic [8:0]  count2;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_mem[150];

    always #5 clk = ~clk;

    param_stream_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .rd_en(rd_en), .rd_ch(rd_ch), .rd_row(rd_row), .rd_col(rd_col),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
        .count(count), .checksum(checksum)
    );

    param_stream_loader #(.CH(16), .ROWS(5), .COLS(5)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
        .in_valid(in_valid2), .in_data(in_data2), .in_ready(in_ready2),
        .rd_en(rd_en2), .rd_ch(rd_ch2), .rd_row(rd_row2), .rd_col(rd_col2),
        .rd_data(rd_data2), .rd_valid(rd_valid2), .busy(busy2), .done(done2),
        .count(count2), .checksum(checksum2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int c, input int r, input int l, input logic [31:0] e);
        rd_en  = 1'b1;
        rd_ch  = 3'(c);
        rd_row = 3'(r);
        rd_col = 3'(l);
        exp_q.push_back(e);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input logic [31:0] base, input int n, output int rdy);
        rdy = 0;
        for (int k = 0; k < n; k++) begin
            in_valid   = 1'b1;
            in_data    = base + 32'(k);
            exp_mem[k] = base + 32'(k);
            if (in_ready) rdy++;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_count"}, 32'(count), 0);
        check({tag, "_checksum"}, checksum, 0);
        check({tag, "_rd_valid"}, 32'(rd_valid), 0);
        check({tag, "_rd_data"}, rd_data, 0);
    endtask

    always @(negedge clk) begin : monitor
        logic [31:0] e;
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rd_unexpected: got rd_valid=1 data %h expected no read", rd_data);
            end else begin
                e = exp_q.pop_front();
                check("rd_data", rd_data, e);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          rdy;
        int          k;
        int          cycles;
        logic [31:0] model, w;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
        rd_en = 1'b0; rd_ch = '0; rd_row = '0; rd_col = '0;
        start2 = 1'b0; abort2 = 1'b0; in_valid2 = 1'b0; in_data2 = '0;
        rd_en2 = 1'b0; rd_ch2 = '0; rd_row2 = '0; rd_col2 = '0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        #2 rst_n = 1'b1;
        tick();

        // straight load, in_valid held high
        pulse_start();
        check("t1_busy", 32'(busy), 1);
        check("t1_count0", 32'(count), 0);
        feed(32'h3F800000, 150, rdy);
        check("t1_ready_cycles", 32'(rdy), 150);
        check("t1_done", 32'(done), 1);
        check("t1_busy_end", 32'(busy), 0);
        check("t1_in_ready_end", 32'(in_ready), 0);
        check("t1_count", 32'(count), 150);
        check("t1_checksum", checksum, 32'h00000001);
        in_valid = 1'b1; in_data = 32'hFFFFFFFF;
        tick(); tick();
        in_valid = 1'b0;
        check("t1_count_hold", 32'(count), 150);
        check("t1_checksum_hold", checksum, 32'h00000001);
        rd(5, 4, 4, 32'h3F800095);
        check("t1_rd_valid_now", 32'(rd_valid), 1);
        tick();
        check("t1_rd_valid_off", 32'(rd_valid), 0);

        // gapped load; same-cycle read of address 0 sees the previous load's word
        pulse_start();
        check("t2_count0", 32'(count), 0);
        check("t2_checksum0", checksum, 0);
        check("t2_done0", 32'(done), 0);
        check("t2_busy", 32'(busy), 1);
        k = 0;
        cycles = 0;
        while (k < 150 && cycles < 400) begin
            if (cycles % 2 == 0) begin
                in_valid   = 1'b1;
                in_data    = 32'h40000000 | (32'(k) << 8);
                exp_mem[k] = in_data;
                k++;
            end else begin
                in_valid = 1'b0;
                in_data  = 32'hDEADBEEF;
            end
            if (cycles == 0) begin
                rd_en = 1'b1; rd_ch = 3'd0; rd_row = 3'd0; rd_col = 3'd0;
                exp_q.push_back(32'h3F800000);
            end
            start = (cycles == 11);
            tick();
            rd_en = 1'b0;
            start = 1'b0;
            cycles++;
        end
        in_valid = 1'b0;
        check("t2_cycles", 32'(cycles), 299);
        check("t2_done", 32'(done), 1);
        check("t2_count", 32'(count), 150);
        check("t2_checksum", checksum, 32'h00000100);
        rd(6, 0, 0, 32'h0);
        rd(0, 5, 0, 32'h0);
        rd(0, 0, 5, 32'h0);
        for (int a = 0; a < 150; a++) rd(a / 25, (a / 5) % 5, a % 5, exp_mem[a]);
        tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t2_abort_in_done", 32'(done), 1);
        check("t2_count_after_abort", 32'(count), 150);

        // abort with a same-cycle valid word
        pulse_start();
        feed(32'h11110000, 37, rdy);
        in_valid = 1'b1; in_data = 32'h11110025; abort = 1'b1;
        tick();
        abort = 1'b0; in_valid = 1'b0;
        check("t3_busy", 32'(busy), 0);
        check("t3_done", 32'(done), 0);
        check("t3_in_ready", 32'(in_ready), 0);
        check("t3_count", 32'(count), 37);
        check("t3_checksum", checksum, 32'h11110024);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t3_abort_idle_busy", 32'(busy), 0);
        check("t3_abort_idle_count", 32'(count), 37);
        rd(1, 2, 2, 32'h40002500);
        rd(1, 2, 1, 32'h11110024);
        pulse_start();
        check("t3_restart_count", 32'(count), 0);
        check("t3_restart_checksum", checksum, 0);
        check("t3_restart_busy", 32'(busy), 1);

        // asynchronous reset in the middle of a load
        feed(32'h22220000, 80, rdy);
        check("t4_count80", 32'(count), 80);
        rd(0, 0, 0, 32'h22220000);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("t4_async");
        tick(); tick();
        #2 rst_n = 1'b1;
        in_valid = 1'b1; in_data = 32'h12345678;
        repeat (3) tick();
        in_valid = 1'b0;
        check("t4_idle_busy", 32'(busy), 0);
        check("t4_idle_done", 32'(done), 0);
        check("t4_idle_count", 32'(count), 0);
        rst_n = 1'b0;
        tick();
        start = 1'b1;
        #2 rst_n = 1'b1;
        tick();
        start = 1'b0;
        check("t4_first_edge_start", 32'(busy), 1);
        feed(32'h22220000, 149, rdy);
        check("t4_not_done_early", 32'(done), 0);
        in_valid = 1'b1; in_data = 32'h22220095;
        tick();
        in_valid = 1'b0;
        check("t4_done", 32'(done), 1);
        check("t4_count", 32'(count), 150);
        check("t4_checksum", checksum, 32'h00000001);

        // 16-channel instance
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        check("t5_in_ready", 32'(in_ready2), 1);
        check("t5_busy", 32'(busy2), 1);
        model = '0;
        w = '0;
        for (int j = 0; j < 400; j++) begin
            w = 32'hC0000000 ^ (32'(j) * 32'h00010203);
            in_valid2 = 1'b1;
            in_data2  = w;
            model     = model ^ w;
            if (j == 399) check("t5_not_done_early", 32'(done2), 0);
            tick();
        end
        in_valid2 = 1'b0;
        check("t5_done", 32'(done2), 1);
        check("t5_count", 32'(count2), 400);
        check("t5_checksum", checksum2, model);
        rd_en2 = 1'b1; rd_ch2 = 4'd15; rd_row2 = 3'd4; rd_col2 = 3'd4;
        tick();
        rd_en2 = 1'b0;
        check("t5_rd_valid", 32'(rd_valid2), 1);
        check("t5_rd_data", rd_data2, w);

        tick(); tick();
        check("rd_pending", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
